// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU micro-sequencer: state encoding, instruction
// field positions and the ALU opcodes the sequencer knows by name.
package alu_seq_pkg;

   // FSM state encoding
   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StIssue  = 3'd1;
   localparam logic [2:0] StSettle = 3'd2;
   localparam logic [2:0] StPause  = 3'd3;
   localparam logic [2:0] StDone   = 3'd4;

   // Instruction layout: [7]=LAST, [6:4]=extra repeats, [3:0]=ALU select
   localparam int unsigned LAST_BIT = 7;
   localparam int unsigned REP_MSB  = 6;
   localparam int unsigned REP_LSB  = 4;
   localparam int unsigned SEL_MSB  = 3;
   localparam int unsigned SEL_LSB  = 0;

   // ALU opcodes
   localparam logic [3:0] NOP  = 4'h0;
   localparam logic [3:0] SHL  = 4'h2;
   localparam logic [3:0] AND  = 4'h5;
   localparam logic [3:0] SWP  = 4'hE;
   localparam logic [3:0] LOAD = 4'hF;

   // Power-on program entry: a lone no-op that ends the run
   localparam logic [7:0] INSTR_INIT = 8'h80;

endpackage

// File: rtl/alu_seq_prog_mem.sv
// Program store for the sequencer: DEPTH x 8 register file, one write port,
// one asynchronous read port, every entry reset to a LAST no-op.
module alu_seq_prog_mem
   import alu_seq_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem_q [DEPTH];
   logic [7:0] mem_d [DEPTH];

   // Next contents: single-entry write when enabled
   always_comb begin
      mem_d = mem_q;
      if (we_i) begin
         mem_d[waddr_i] = wdata_i;
      end
   end

   // Storage, re-initialised on reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= INSTR_INIT;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Micro-sequencer for the register ALU: walks a loadable program, issuing
// each op as select + one-cycle do strobe, with repeats, settle gaps,
// optional single-step pauses between entries, and abort.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned DEPTH         = 16,
   parameter int unsigned SETTLE_CYCLES = 1,
   localparam int unsigned AW           = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [7:0]    prog_data,
   input  logic          start,
   input  logic          step_mode,
   input  logic          step,
   input  logic          abort,
   output logic          alu_do,
   output logic [3:0]    alu_select,
   output logic          busy,
   output logic          done,
   output logic          aborted,
   output logic          prog_err,
   output logic [AW-1:0] pc
);

   localparam logic [3:0]    SettleInit = 4'(SETTLE_CYCLES - 1);
   localparam logic [AW-1:0] PcLast     = AW'(DEPTH - 1);

   logic [2:0]    state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [7:0]    ir_q, ir_d;
   logic [2:0]    rep_cnt_q, rep_cnt_d;
   logic [3:0]    settle_cnt_q, settle_cnt_d;
   logic          alu_do_q, alu_do_d;
   logic [3:0]    alu_select_q, alu_select_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          aborted_q, aborted_d;
   logic          prog_err_q, prog_err_d;

   logic          mem_we;
   logic [AW-1:0] mem_raddr;
   logic [7:0]    mem_rdata;

   // In IDLE we prefetch entry 0 for start; otherwise the entry after pc
   assign mem_raddr = (state_q == StIdle) ? '0 : pc_q + 1'b1;
   assign mem_we    = prog_we && (state_q == StIdle);

   alu_seq_prog_mem #(
      .DEPTH (DEPTH)
   ) u_prog_mem (
      .clk     (clk),
      .reset   (reset),
      .we_i    (mem_we),
      .waddr_i (prog_addr),
      .wdata_i (prog_data),
      .raddr_i (mem_raddr),
      .rdata_o (mem_rdata)
   );

   // Sequencing FSM and registered-output next state
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ir_d         = ir_q;
      rep_cnt_d    = rep_cnt_q;
      settle_cnt_d = settle_cnt_q;
      aborted_d    = 1'b0;
      prog_err_d   = prog_we && (state_q != StIdle);

      case (state_q)
         StIdle: begin
            // A same-cycle write takes precedence over start
            if (start && !prog_we) begin
               state_d   = StIssue;
               pc_d      = '0;
               ir_d      = mem_rdata;
               rep_cnt_d = mem_rdata[REP_MSB:REP_LSB];
            end
         end
         StIssue: begin
            state_d      = StSettle;
            settle_cnt_d = SettleInit;
         end
         StSettle: begin
            if (settle_cnt_q != 4'd0) begin
               settle_cnt_d = settle_cnt_q - 4'd1;
            end else if (rep_cnt_q != 3'd0) begin
               // Repeats of the same entry never pause
               rep_cnt_d = rep_cnt_q - 3'd1;
               state_d   = StIssue;
            end else if (ir_q[LAST_BIT] || pc_q == PcLast) begin
               state_d = StDone;
            end else begin
               pc_d      = pc_q + 1'b1;
               ir_d      = mem_rdata;
               rep_cnt_d = mem_rdata[REP_MSB:REP_LSB];
               state_d   = step_mode ? StPause : StIssue;
            end
         end
         StPause: begin
            if (step || !step_mode) begin
               state_d = StIssue;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (abort && state_q != StIdle) begin
         state_d      = StIdle;
         pc_d         = '0;
         rep_cnt_d    = 3'd0;
         settle_cnt_d = 4'd0;
         aborted_d    = 1'b1;
      end

      alu_do_d = (state_d == StIssue);
      done_d   = (state_d == StDone);
      busy_d   = (state_d != StIdle) && (state_d != StDone);

      // Select changes only on a new issue or when returning to IDLE
      alu_select_d = alu_select_q;
      if (state_d == StIssue) begin
         alu_select_d = ir_d[SEL_MSB:SEL_LSB];
      end else if (state_d == StIdle) begin
         alu_select_d = NOP;
      end
   end

   // State, counters and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         pc_q         <= '0;
         ir_q         <= INSTR_INIT;
         rep_cnt_q    <= 3'd0;
         settle_cnt_q <= 4'd0;
         alu_do_q     <= 1'b0;
         alu_select_q <= NOP;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
         prog_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ir_q         <= ir_d;
         rep_cnt_q    <= rep_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         alu_do_q     <= alu_do_d;
         alu_select_q <= alu_select_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         aborted_q    <= aborted_d;
         prog_err_q   <= prog_err_d;
      end
   end

   assign alu_do     = alu_do_q;
   assign alu_select = alu_select_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign aborted    = aborted_q;
   assign prog_err   = prog_err_q;
   assign pc         = pc_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios plus random
// programs, checked against a run-level model of issue times and selects.
module tb_alu_sequencer;
   import alu_seq_pkg::*;

   localparam int unsigned Depth  = 16;
   localparam int unsigned Aw     = 4;
   localparam int unsigned Settle = 1;

   logic          clk;
   logic          reset;
   logic          prog_we;
   logic [Aw-1:0] prog_addr;
   logic [7:0]    prog_data;
   logic          start;
   logic          step_mode;
   logic          step;
   logic          abort;
   logic          alu_do;
   logic [3:0]    alu_select;
   logic          busy;
   logic          done;
   logic          aborted;
   logic          prog_err;
   logic [Aw-1:0] pc;

   int unsigned n_tests;
   int unsigned n_fail;
   logic [7:0]  model_mem [Depth];

   alu_sequencer #(
      .DEPTH         (Depth),
      .SETTLE_CYCLES (Settle)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .start      (start),
      .step_mode  (step_mode),
      .step       (step),
      .abort      (abort),
      .alu_do     (alu_do),
      .alu_select (alu_select),
      .busy       (busy),
      .done       (done),
      .aborted    (aborted),
      .prog_err   (prog_err),
      .pc         (pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_prog(input int unsigned addr, input logic [7:0] data);
      prog_we   = 1'b1;
      prog_addr = Aw'(addr);
      prog_data = data;
      tick();
      prog_we = 1'b0;
      model_mem[addr] = data;
   endtask

   task automatic model_reset();
      for (int i = 0; i < int'(Depth); i++) model_mem[i] = 8'h80;
   endtask

   // Free-running run: predict every do pulse (cycle, select), the done cycle
   // and the final pc from the program, then compare the observed trace.
   task automatic run_free(input string tag);
      int          exp_cyc[$];
      int          exp_sel[$];
      int          obs_cyc[$];
      int          obs_sel[$];
      int          off;
      int          p;
      int          last_pc;
      int          done_cyc;
      int          n_done;
      logic [7:0]  instr;
      off     = 1;
      p       = 0;
      last_pc = 0;
      for (int guard = 0; guard < int'(Depth); guard++) begin
         instr = model_mem[p];
         for (int r = 0; r <= int'(instr[6:4]); r++) begin
            exp_cyc.push_back(off);
            exp_sel.push_back(int'(instr[3:0]));
            off += 1 + int'(Settle);
         end
         last_pc = p;
         if (instr[7] || p == int'(Depth) - 1) break;
         p++;
      end
      done_cyc = off;
      n_done   = 0;
      start    = 1'b1;
      for (int c = 1; c <= done_cyc + 1; c++) begin
         tick();
         if (c == 1) start = 1'b0;
         if (alu_do) begin
            obs_cyc.push_back(c);
            obs_sel.push_back(int'(alu_select));
         end
         if (done) n_done++;
         if (c == 1) check_eq({tag, " busy first"}, busy, 1);
         if (c == done_cyc - 1) check_eq({tag, " busy last"}, busy, 1);
         if (c == done_cyc) begin
            check_eq({tag, " done"}, done, 1);
            check_eq({tag, " pc at done"}, pc, last_pc);
            check_eq({tag, " busy at done"}, busy, 0);
            check_eq({tag, " sel held"}, alu_select, exp_sel[exp_sel.size() - 1]);
         end
         if (c == done_cyc + 1) begin
            check_eq({tag, " idle busy"}, busy, 0);
            check_eq({tag, " idle sel"}, alu_select, 0);
         end
      end
      check_eq({tag, " done pulses"}, n_done, 1);
      check_eq({tag, " do count"}, obs_cyc.size(), exp_cyc.size());
      for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
         check_eq({tag, " do cycle"}, obs_cyc[i], exp_cyc[i]);
         check_eq({tag, " do sel"}, obs_sel[i], exp_sel[i]);
      end
   endtask

   // Bounded wait for done; returns the pc seen with it
   task automatic wait_done(input string tag, input int limit, output int pc_at);
      bit seen;
      seen  = 1'b0;
      pc_at = -1;
      for (int c = 0; c < limit && !seen; c++) begin
         tick();
         if (done) begin
            seen  = 1'b1;
            pc_at = int'(pc);
         end
      end
      check_eq({tag, " done seen"}, seen, 1);
   endtask

   initial begin
      int         cnt;
      int         pc_at;
      int         len;
      logic [7:0] d;
      n_tests   = 0;
      n_fail    = 0;
      reset     = 1'b1;
      prog_we   = 1'b0;
      prog_addr = '0;
      prog_data = 8'h00;
      start     = 1'b0;
      step_mode = 1'b0;
      step      = 1'b0;
      abort     = 1'b0;
      model_reset();

      // 1: reset state, then the default program
      tick();
      tick();
      check_eq("rst alu_do", alu_do, 0);
      check_eq("rst busy", busy, 0);
      check_eq("rst done", done, 0);
      check_eq("rst pc", pc, 0);
      check_eq("rst sel", alu_select, 0);
      check_eq("rst aborted", aborted, 0);
      reset = 1'b0;
      tick();
      run_free("t1");

      // 2: LOAD then AND+LAST
      write_prog(0, {4'h0, LOAD});
      write_prog(1, {4'h8, AND});
      run_free("t2");

      // 3: one entry repeated four times
      write_prog(0, {4'hB, SHL});
      run_free("t3");

      // 4: single-step pauses between entries
      write_prog(0, 8'h07);
      write_prog(1, 8'h8B);
      step_mode = 1'b1;
      start     = 1'b1;
      tick();
      start = 1'b0;
      check_eq("t4 first do", alu_do, 1);
      check_eq("t4 first sel", alu_select, 7);
      tick();
      tick();
      check_eq("t4 paused pc", pc, 1);
      check_eq("t4 paused busy", busy, 1);
      cnt = 0;
      repeat (4) begin
         tick();
         if (alu_do) cnt++;
      end
      check_eq("t4 no do while paused", cnt, 0);
      step = 1'b1;
      tick();
      step = 1'b0;
      check_eq("t4 step do", alu_do, 1);
      check_eq("t4 step sel", alu_select, 11);
      wait_done("t4", 6, pc_at);
      check_eq("t4 pc at done", pc_at, 1);
      tick();

      // 4b: dropping step_mode while paused resumes on the next cycle
      write_prog(1, 8'h83);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check_eq("t4b paused", alu_do, 0);
      step_mode = 1'b0;
      tick();
      check_eq("t4b resume do", alu_do, 1);
      check_eq("t4b resume sel", alu_select, 3);
      wait_done("t4b", 6, pc_at);
      tick();

      // 5: abort in SETTLE of entry 2, then abort while idle
      write_prog(0, 8'h01);
      write_prog(1, 8'h02);
      write_prog(2, 8'h83);
      start = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         tick();
         start = 1'b0;
      end
      check_eq("t5 in settle pc", pc, 2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_eq("t5 aborted", aborted, 1);
      check_eq("t5 busy", busy, 0);
      check_eq("t5 done", done, 0);
      check_eq("t5 pc", pc, 0);
      check_eq("t5 alu_do", alu_do, 0);
      cnt = 0;
      repeat (4) begin
         tick();
         if (aborted || done || alu_do) cnt++;
      end
      check_eq("t5 quiet after abort", cnt, 0);
      abort = 1'b1;
      step  = 1'b1;
      tick();
      abort = 1'b0;
      step  = 1'b0;
      check_eq("t5 idle abort", aborted, 0);
      check_eq("t5 idle step busy", busy, 0);

      // 6: write while busy is dropped; start with write in IDLE is a write
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      prog_we   = 1'b1;
      prog_addr = '0;
      prog_data = 8'h8C;
      tick();
      prog_we = 1'b0;
      check_eq("t6 prog_err", prog_err, 1);
      tick();
      check_eq("t6 prog_err pulse", prog_err, 0);
      wait_done("t6 busy run", 10, pc_at);
      tick();
      run_free("t6 readback");
      prog_we   = 1'b1;
      start     = 1'b1;
      prog_addr = '0;
      prog_data = 8'h8D;
      tick();
      prog_we = 1'b0;
      start   = 1'b0;
      model_mem[0] = 8'h8D;
      check_eq("t6 no run busy", busy, 0);
      check_eq("t6 no run do", alu_do, 0);
      check_eq("t6 no prog_err", prog_err, 0);
      tick();
      check_eq("t6 still idle", busy, 0);
      run_free("t6 write");

      // Full program with no LAST flag stops at the last entry
      for (int i = 0; i < int'(Depth); i++) write_prog(i, {4'h0, 4'(i)});
      run_free("full");

      // Reset mid-run: no pulses, program re-initialised
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      #1;
      check_eq("mid rst busy", busy, 0);
      check_eq("mid rst do", alu_do, 0);
      check_eq("mid rst done", done, 0);
      check_eq("mid rst aborted", aborted, 0);
      tick();
      reset = 1'b0;
      model_reset();
      tick();
      run_free("after rst");

      // Random programs
      for (int it = 0; it < 10; it++) begin
         len = int'($urandom_range(1, 6));
         for (int i = 0; i < len; i++) begin
            d = {(i == len - 1), 3'($urandom_range(0, 3)), 4'($urandom)};
            write_prog(i, d);
         end
         run_free($sformatf("rand%0d", it));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
